// File: rtl/mem_backend.sv
// Fixed-latency, in-order backing memory behind the mshr: a request FIFO feeds a
// single active slot that waits LATENCY cycles, then commits a write or returns a load.
module mem_backend #(
   parameter int DEPTH_WORDS = 1024,
   parameter int LATENCY     = 4,
   parameter int QDEPTH      = 4,
   parameter int TAG_W       = 6
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic             req_write,
   input  logic [31:0]      req_addr,
   input  logic [31:0]      req_wdata,
   input  logic [TAG_W-1:0] req_tag,
   output logic             resp_valid,
   output logic [TAG_W-1:0] resp_tag,
   output logic [31:0]      resp_addr,
   output logic [31:0]      resp_data,
   output logic             busy
);
   localparam int AW    = $clog2(DEPTH_WORDS);
   localparam int PW    = $clog2(QDEPTH);
   localparam int CW    = PW + 1;
   localparam int CNT_W = $clog2(LATENCY + 1);
   localparam logic [CW-1:0]    QD_FULL = CW'(QDEPTH);
   localparam logic [CNT_W-1:0] LAT_LD  = CNT_W'(LATENCY);
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   typedef struct packed {
      logic             write;
      logic [31:0]      addr;
      logic [31:0]      wdata;
      logic [TAG_W-1:0] tag;
   } req_t;

   typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

   state_t            state, state_nxt;
   req_t              q [QDEPTH];
   req_t              act;
   logic [PW-1:0]     wr_ptr, rd_ptr;
   logic [CW-1:0]     count;
   logic [CNT_W-1:0]  cnt;
   logic              push, pop, done, commit;
   logic [AW-1:0]     act_idx;
   logic [31:0]       mem [DEPTH_WORDS];

   // Upper address bits are dropped, so out-of-range addresses alias.
   assign act_idx = act.addr[AW+1:2];
   assign push    = req_valid && req_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (count != '0) state_nxt = WAIT;
         WAIT:    if (cnt == CNT_ONE) state_nxt = RESP;
         RESP:    state_nxt = (count != '0) ? WAIT : IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // No pop bypass on req_ready: a full FIFO refuses even while popping.
   always_comb begin
      req_ready = (count < QD_FULL);
      busy      = (count != '0) || (state != IDLE);
      pop       = (state == IDLE || state == RESP) && (count != '0);
      done      = (state == WAIT) && (cnt == CNT_ONE);
      commit    = rst && done && act.write;
   end

   always_ff @(posedge clk) begin
      if (push) q[wr_ptr] <= '{write: req_write, addr: req_addr, wdata: req_wdata, tag: req_tag};
   end

   // Array is deliberately outside reset so committed data survives rst.
   always_ff @(posedge clk) begin
      if (commit) mem[act_idx] <= act.wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= '0;
         rd_ptr     <= '0;
         count      <= '0;
         cnt        <= '0;
         act        <= '0;
         resp_valid <= 1'b0;
         resp_tag   <= '0;
         resp_addr  <= '0;
         resp_data  <= '0;
      end else begin
         resp_valid <= 1'b0;
         if (push) wr_ptr <= wr_ptr + PW'(1);
         if (pop)  rd_ptr <= rd_ptr + PW'(1);
         case ({push, pop})
            2'b10:   count <= count + CW'(1);
            2'b01:   count <= count - CW'(1);
            default: count <= count;
         endcase
         if (pop) begin
            act <= q[rd_ptr];
            cnt <= LAT_LD;
         end else if (state == WAIT) begin
            cnt <= cnt - CNT_ONE;
            if (done && !act.write) begin
               resp_valid <= 1'b1;
               resp_tag   <= act.tag;
               resp_addr  <= act.addr;
               resp_data  <= mem[act_idx];
            end
         end
      end
   end
endmodule

// File: tb/tb_mem_backend.sv
// Scoreboard bench for mem_backend: expected load responses are queued at acceptance
// and matched in order against resp_valid pulses.
module tb_mem_backend;
   localparam int LAT = 4;
   localparam int TW  = 6;

   logic          clk = 1'b0, rst = 1'b0;
   logic          req_valid = 1'b0, req_write = 1'b0;
   logic [31:0]   req_addr = '0, req_wdata = '0;
   logic [TW-1:0] req_tag = '0;
   logic          req_ready, resp_valid, busy;
   logic [TW-1:0] resp_tag;
   logic [31:0]   resp_addr, resp_data;

   mem_backend #(.DEPTH_WORDS(1024), .LATENCY(LAT), .QDEPTH(4), .TAG_W(TW)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata), .req_tag(req_tag),
      .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_addr(resp_addr),
      .resp_data(resp_data), .busy(busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      logic [TW-1:0] tag;
      logic [31:0]   addr;
      logic [31:0]   data;
   } exp_t;

   exp_t sb[$];
   int   rcyc[$];
   int   errs = 0, checks = 0;
   int   acc;
   int   acq[6];

   task automatic chk(input string t, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errs++;
         $display("FAIL %s: got %h expected %h", t, got, exp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (rst && resp_valid) begin
         rcyc.push_back(cyc);
         if (sb.size() == 0) chk("unexpected_resp", 32'd1, 32'd0);
         else begin
            e = sb.pop_front();
            chk("resp_tag", 32'(resp_tag), 32'(e.tag));
            chk("resp_addr", resp_addr, e.addr);
            chk("resp_data", resp_data, e.data);
         end
      end
   end

   // Holds req_valid until accepted; acc gets the acceptance edge index.
   task automatic send(input bit w, input logic [31:0] a, input logic [31:0] d,
                       input logic [TW-1:0] t, input logic [31:0] ed);
      int n;
      bit ok;
      n  = 0;
      ok = 1'b0;
      @(negedge clk);
      req_valid = 1'b1; req_write = w; req_addr = a; req_wdata = d; req_tag = t;
      while (!ok && n < 50) begin
         ok = req_ready;
         @(posedge clk);
         if (!ok) @(negedge clk);
         n++;
      end
      if (!ok) chk("accept_timeout", 32'd0, 32'd1);
      #1;
      acc = cyc;
      if (!w) sb.push_back('{tag: t, addr: a, data: ed});
   endtask

   task automatic idle();
      @(negedge clk);
      req_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      idle();
      while ((sb.size() != 0 || busy) && n < 200) begin
         @(negedge clk);
         n++;
      end
      chk("drain_timeout", 32'(n < 200), 32'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: got running expected done");
      $fatal(1);
   end

   initial begin
      #1;
      chk("rst_ready", 32'(req_ready), 32'd1);
      chk("rst_resp_valid", 32'(resp_valid), 32'd0);
      chk("rst_resp_tag", 32'(resp_tag), 32'd0);
      chk("rst_resp_addr", resp_addr, 32'd0);
      chk("rst_resp_data", resp_data, 32'd0);
      chk("rst_busy", 32'(busy), 32'd0);
      repeat (2) @(negedge clk);
      rst = 1'b1;

      // preload then read back
      send(1'b1, 32'h40, 32'h0000_00AA, 6'h00, 32'h0);
      send(1'b0, 32'h40, 32'h0, 6'h25, 32'h0000_00AA);
      drain();

      // latency from an idle unit
      repeat (3) @(negedge clk);
      rcyc.delete();
      send(1'b0, 32'h40, 32'h0, 6'h02, 32'h0000_00AA);
      acq[0] = acc;
      drain();
      chk("lat_nresp", 32'(rcyc.size()), 32'd1);
      if (rcyc.size() > 0) chk("lat_edge", 32'(rcyc[0]), 32'(acq[0] + LAT + 1));

      // full FIFO with back-to-back loads
      for (int i = 0; i < 6; i++) send(1'b1, 32'h100 + 32'(4 * i), 32'h1000 + 32'(i), 6'h0, 32'h0);
      drain();
      rcyc.delete();
      for (int i = 0; i < 6; i++) begin
         send(1'b0, 32'h100 + 32'(4 * i), 32'h0, 6'(i), 32'h1000 + 32'(i));
         acq[i] = acc;
         if (i == 4) chk("full_ready", 32'(req_ready), 32'd0);
      end
      drain();
      chk("full_burst_accept", 32'(acq[4] - acq[0]), 32'd4);
      chk("full_sixth_accept", 32'(acq[5] - acq[0]), 32'd7);
      chk("full_nresp", 32'(rcyc.size()), 32'd6);
      if (rcyc.size() > 0) chk("full_first_edge", 32'(rcyc[0]), 32'(acq[0] + LAT + 1));
      for (int i = 1; i < rcyc.size(); i++) chk("full_spacing", 32'(rcyc[i] - rcyc[i-1]), 32'(LAT + 1));

      // write-write-read ordering
      rcyc.delete();
      send(1'b1, 32'h80, 32'h1234, 6'h0, 32'h0);
      send(1'b1, 32'h80, 32'h5678, 6'h0, 32'h0);
      send(1'b0, 32'h80, 32'h0, 6'h07, 32'h5678);
      drain();
      chk("order_nresp", 32'(rcyc.size()), 32'd1);

      // reset mid-flight
      send(1'b0, 32'h80, 32'h0, 6'h09, 32'h5678);
      idle();
      @(posedge clk);
      @(posedge clk);
      #1 rst = 1'b0;
      #1;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_ready", 32'(req_ready), 32'd1);
      chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
      chk("midrst_resp_data", resp_data, 32'd0);
      sb.delete();
      @(negedge clk);
      rst = 1'b1;
      rcyc.delete();
      repeat (12) @(negedge clk);
      chk("midrst_no_resp", 32'(rcyc.size()), 32'd0);
      chk("midrst_idle", 32'(busy), 32'd0);
      send(1'b0, 32'h80, 32'h0, 6'h0A, 32'h5678);
      send(1'b0, 32'h40, 32'h0, 6'h0B, 32'h0000_00AA);
      drain();

      // address aliasing past the array
      send(1'b1, 32'h0000_0004, 32'hBEEF, 6'h0, 32'h0);
      send(1'b0, 32'h0000_1004, 32'h0, 6'h3F, 32'hBEEF);
      drain();

      chk("sb_empty", 32'(sb.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule

// File: doc/mem_backend.md
# mem_backend

Fixed-latency, in-order backing memory that sits directly downstream of the `mshr`. It accepts word-granular load-fill and eviction-writeback requests through a valid/ready handshake and buffers them in a small FIFO. It services them one at a time after a programmable latency and returns load data with the request's tag echoed back, so `mshr` can match each fill to its `regD` and `way`.

## Interface

Parameters:
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `LATENCY`, default 4: wait cycles per request; at least 1.
- `QDEPTH`, default 4: request FIFO entries; power of two, at least 2.
- `TAG_W`, default 6: tag width (`{way, regD[4:0]}`).

Ports (one clock; reset is asynchronous and active-low):
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  asynchronous active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  FIFO can accept a request.
- `req_write`  in  1  1 = eviction write, 0 = load fill.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  write data; ignored for loads.
- `req_tag`  in  TAG_W  opaque tag; echoed on load responses.
- `resp_valid`  out  1  one-cycle pulse, load data valid.
- `resp_tag`  out  TAG_W  tag of the completed load.
- `resp_addr`  out  32  address of the completed load.
- `resp_data`  out  32  loaded word.
- `busy`  out  1  FIFO non-empty or state ≠ IDLE.

## Operation

Handshake and FIFO:
- A request is accepted on an edge where `req_valid && req_ready`.
- `req_ready` = (count < QDEPTH). It uses no same-cycle pop bypass, so a full FIFO refuses requests even on a pop cycle.
- Requests are pushed into a FIFO with wrap-around read/write pointers. Service is strictly in order, so read-after-write to the same address always returns the new data.

Addressing:
- Word index = `req_addr[$clog2(DEPTH_WORDS)+1:2]`.
- `addr[1:0]` is ignored.
- Upper bits are ignored, so out-of-range addresses alias and wrap.

FSM states: IDLE, WAIT, RESP.
- IDLE: if the FIFO is non-empty, pop the head into the active register, load `cnt` = LATENCY, and go to WAIT.
- WAIT: `cnt` decrements every cycle. When `cnt` == 1, go to RESP.
  - On that same edge, a write commits `wdata` to the array.
  - On that same edge, a load registers `resp_data` = array[index] plus `resp_tag` and `resp_addr`.
- RESP (lasts 1 cycle): `resp_valid` = 1 for loads only; writes produce no response.
  - If the FIFO is non-empty, pop the next request and go to WAIT with `cnt` = LATENCY.
  - Otherwise go to IDLE.
- A push and a pop on the same edge leave count unchanged.

Reset:
- Asynchronous assertion clears the FIFO pointers and count, and forces state = IDLE with `cnt` = 0.
- An in-flight request is dropped with no response.
- A write that has not yet reached RESP never commits.
- Array contents are not reset and persist across `rst`.

## Timing

- Reset values of outputs:
  - `req_ready` = 1
  - `resp_valid` = 0
  - `resp_tag` = 0
  - `resp_addr` = 0
  - `resp_data` = 0
  - `busy` = 0
- Load into an empty, idle unit accepted at edge E: `resp_valid` is sampled high at edge E+LATENCY+2 and only there. With LATENCY = 4: accepted at edge 0, response sampled at edge 6.
- Write accepted at edge E (empty and idle): the array is updated at edge E+LATENCY+1.
- Steady-state throughput: one request per LATENCY+1 cycles, since RESP chains directly into WAIT.
- `resp_tag`, `resp_addr` and `resp_data` hold their value until the next load response.
- `busy` is combinational from state and count. `req_ready` is combinational from count.

## Test plan

1. Preload: write 0x0000_00AA to address 0x40 at edge 0, then load 0x40 with tag 0x25 at edge 1. Required: one `resp_valid` pulse with `resp_data` = 0xAA, `resp_tag` = 0x25, `resp_addr` = 0x40.
2. Latency: with LATENCY = 4 and the unit idle, load accepted at edge 10. Required: `resp_valid` high only at edge 16.
3. Full FIFO: hold `req_valid` high with 6 loads while the unit is idle. Required:
   - 1 request is popped and 4 are queued;
   - `req_ready` falls after the 5th acceptance;
   - the 6th is held until the first RESP pop;
   - all 6 responses return in order, with tags 0–5 spaced 5 cycles apart.
4. Ordering: write 0x1234 then 0x5678 to address 0x80, then load 0x80 back-to-back. Required: `resp_data` = 0x5678; exactly one response.
5. Reset mid-operation: accept a load, then pulse `rst` low at edge +2. Required:
   - no `resp_valid` afterwards;
   - `busy` = 0 and `req_ready` = 1 immediately;
   - earlier committed array data is still readable.
6. Wrap: write 0xBEEF to address 0x0000_0004, then load 0x0000_1004 (DEPTH_WORDS = 1024). Required: `resp_data` = 0xBEEF.
